// File: rtl/sc01_pkg.sv
// Shared types and constants for the SC01 speech timing controller.
// Holds the phoneme duration table, the STOP code and the sequencer state type.
package sc01_pkg;

    localparam int SC01_DUR_W = 5;

    localparam logic [5:0] PH_STOP = 6'h3F;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPEAK = 1'b1
    } sc01_state_e;

    // Phoneme durations in 10 ms frames. Codes without a characterised
    // duration use a mid-length default of 8 frames.
    localparam logic [SC01_DUR_W-1:0] DUR_TABLE [0:63] = '{
        0:       5'd6,
        3:       5'd1,
        43:      5'd7,
        62:      5'd19,
        63:      5'd0,
        default: 5'd8
    };

endpackage

// File: rtl/sc01_sequencer_frac_ce_gen.sv
// Fractional clock-enable generator: ACC_INC pulses every ACC_MOD clocks, no drift.
// Reusable for any board clock ratio where ACC_MOD > ACC_INC.
module frac_ce_gen #(
    parameter int ACC_INC = 9,
    parameter int ACC_MOD = 500
) (
    input  logic clk,
    input  logic rst,
    output logic ce
);

    localparam int W = $clog2(ACC_MOD) + 1;
    localparam logic [W-1:0] INC = W'(ACC_INC);
    localparam logic [W-1:0] MOD = W'(ACC_MOD);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] sum;
    logic         ce_q;
    logic         ce_d;

    // W bits hold up to 2*ACC_MOD-1, so the sum never overflows.
    always_comb begin
        sum = acc_q + INC;
        if (sum >= MOD) begin
            acc_d = sum - MOD;
            ce_d  = 1'b1;
        end else begin
            acc_d = sum;
            ce_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/sc01_sequencer.sv
// SC01 phoneme sequencer: captures strobed phoneme writes, times each phoneme
// from the duration table and drives the active-high-ready AR line to the CPU.
module sc01_sequencer
    import sc01_pkg::*;
#(
    parameter int ACC_INC   = 9,
    parameter int ACC_MOD   = 500,
    parameter int FRAME_DIV = 7200,
    parameter int DUR_W     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        latch_n,
    input  logic [5:0]  phcde,
    input  logic [1:0]  pitch_in,
    output logic        ce_720k,
    output logic        frame_tick,
    output logic [5:0]  phoneme,
    output logic [1:0]  pitch,
    output logic        busy,
    output logic        ar,
    output sc01_state_e state_dbg
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    sc01_state_e      state_q, state_d;
    logic             latch_q, latch_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [5:0]       phoneme_q, phoneme_d;
    logic [1:0]       pitch_q, pitch_d;
    logic             busy_q, busy_d;
    logic             ar_q, ar_d;
    logic             frame_tick_q, frame_tick_d;

    logic             capture;
    logic [DUR_W-1:0] tbl_dur;
    logic [DUR_W-1:0] load_dur;

    frac_ce_gen #(
        .ACC_INC (ACC_INC),
        .ACC_MOD (ACC_MOD)
    ) u_ce_gen (
        .clk (clk),
        .rst (reset),
        .ce  (ce_720k)
    );

    always_comb begin
        latch_d  = latch_n;
        capture  = latch_q & ~latch_n;
        tbl_dur  = DUR_W'(DUR_TABLE[phcde]);
        // A zero-length entry still occupies one frame.
        load_dur = (tbl_dur == '0) ? DUR_W'(1) : tbl_dur;

        state_d      = state_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        phoneme_d    = phoneme_q;
        pitch_d      = pitch_q;
        busy_d       = busy_q;
        ar_d         = ar_q;
        frame_tick_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    phoneme_d = phcde;
                    pitch_d   = pitch_in;
                    if (phcde != PH_STOP) begin
                        state_d = ST_SPEAK;
                        cnt_d   = load_dur;
                        div_d   = '0;
                        busy_d  = 1'b1;
                        ar_d    = 1'b0;
                    end
                end
            end
            ST_SPEAK: begin
                // A new strobe wins over any frame boundary in the same cycle.
                if (capture) begin
                    phoneme_d = phcde;
                    pitch_d   = pitch_in;
                    div_d     = '0;
                    if (phcde == PH_STOP) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        ar_d    = 1'b1;
                    end else begin
                        cnt_d = load_dur;
                    end
                end else if (ce_720k) begin
                    if (div_q == DIV_LAST) begin
                        div_d        = '0;
                        frame_tick_d = 1'b1;
                        cnt_d        = cnt_q - 1'b1;
                        if (cnt_q <= DUR_W'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            busy_d  = 1'b0;
                            ar_d    = 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                ar_d    = 1'b1;
            end
        endcase
    end

    // Latch register resets low so a strobe held through reset is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            latch_q      <= 1'b0;
            div_q        <= '0;
            cnt_q        <= '0;
            phoneme_q    <= PH_STOP;
            pitch_q      <= 2'b00;
            busy_q       <= 1'b0;
            ar_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            latch_q      <= latch_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            phoneme_q    <= phoneme_d;
            pitch_q      <= pitch_d;
            busy_q       <= busy_d;
            ar_q         <= ar_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
    assign phoneme    = phoneme_q;
    assign pitch      = pitch_q;
    assign busy       = busy_q;
    assign ar         = ar_q;
    assign state_dbg  = state_q;

endmodule
